// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, data width and idle line level.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, resetting to a chosen level.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte output, framing-error and overrun status.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIVIDER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int            CW          = $clog2(DIVIDER);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(DIVIDER / 2 - 1);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIVIDER - 1);

  uart_state_t               state;
  logic [CW-1:0]             cnt;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      rx_s;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(UART_IDLE_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // A handshake clears VALID/OVERRUN first; a stop-bit delivery later in the block overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (valid && ready) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF_RELOAD;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DATA;
            cnt   <= BIT_RELOAD;
            idx   <= '0;
          end
        end

        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shift[idx] <= rx_s;
            cnt        <= BIT_RELOAD;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end
        end

        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!valid || ready) begin
              data  <= shift;
              valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end
        end

        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model plus directed scenarios.
module tb_uart_rx;

  localparam int DIVIDER = 4;
  localparam int HALF    = DIVIDER / 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  uart_rx #(.DIVIDER(DIVIDER)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, start_cyc = 0, rise_cyc = 0, rise_cnt = 0;
  int fe_cnt = 0, busy_cnt = 0, valid_hi = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return {24'd0, got[i]};
    return 32'hdead_beef;
  endfunction

  // Reference receiver: line value seen two edges late, bit k sampled HALF + k*DIVIDER edges after start detect.
  int         m_mode, m_t, m_start, m_off, m_k;
  logic       m_d1, m_d2, m_line, m_hs, m_deliver;
  logic [7:0] m_byte, m_data;
  logic       m_valid, m_ov, m_fe, m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_t = 0; m_start = 0;
      m_d1 = 1'b1; m_d2 = 1'b1;
      m_byte = 8'h00; m_data = 8'h00;
      m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_busy = 1'b0;
    end else begin
      m_line = m_d2;
      m_d2 = m_d1;
      m_d1 = rx;
      m_hs = m_valid && ready;
      m_deliver = 1'b0;
      m_fe = 1'b0;
      if (m_mode == 0) begin
        if (!m_line) begin
          m_mode = 1;
          m_start = m_t;
        end
      end else if (m_mode == 1) begin
        m_off = m_t - m_start;
        if (m_off == HALF) begin
          if (m_line) m_mode = 0;
        end else if (m_off > HALF && (m_off - HALF) % DIVIDER == 0) begin
          m_k = (m_off - HALF) / DIVIDER;
          if (m_k <= 8) m_byte[m_k-1] = m_line;
          else if (m_line) begin
            m_deliver = 1'b1;
            m_mode = 0;
          end else begin
            m_fe = 1'b1;
            m_mode = 2;
          end
        end
      end else if (m_line) begin
        m_mode = 0;
      end
      if (m_deliver) begin
        if (!m_valid || m_hs) begin
          m_data = m_byte;
          m_valid = 1'b1;
          m_ov = 1'b0;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_hs) begin
        m_valid = 1'b0;
        m_ov = 1'b0;
      end
      m_busy = (m_mode != 0);
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_output("data", {24'd0, data}, {24'd0, m_data});
      check_output("valid", {31'd0, valid}, {31'd0, m_valid});
      check_output("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
      check_output("overrun", {31'd0, overrun}, {31'd0, m_ov});
      check_output("busy", {31'd0, busy}, {31'd0, m_busy});
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst && valid && ready) got.push_back(data);
    #1;
    if (valid && !prev_valid) begin
      rise_cyc = cyc;
      rise_cnt++;
    end
    prev_valid = valid;
    if (valid) valid_hi++;
    if (frame_err) fe_cnt++;
    if (busy) busy_cnt++;
  end

  // Drives start, 8 data bits LSB first and stop at exact bit timing; cut >= 0 aborts after that many cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int cut);
    logic [9:0] bits;
    int n;
    bits = {stop, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < DIVIDER; j++) begin
        if (n == cut) return;
        @(negedge clk);
        rx = bits[i];
        if (i == 0 && j == 0) start_cyc = cyc;
        n++;
      end
    end
  endtask

  task automatic apply_stimulus_idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int rise0;
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_data", {24'd0, data}, 32'h0);
    check_output("reset_valid", {31'd0, valid}, 32'h0);
    check_output("reset_busy", {31'd0, busy}, 32'h0);
    check_output("reset_overrun", {31'd0, overrun}, 32'h0);
    rst = 1'b0;
    ready = 1'b1;
    apply_stimulus_idle(3);

    $display("[TB] frame 0xA5 with ready high");
    valid_hi = 0; fe_cnt = 0; got.delete();
    send_frame(8'hA5, 1'b1, -1);
    apply_stimulus_idle(6);
    check_output("t1_latency", rise_cyc - start_cyc, 32'd41);
    check_output("t1_valid_cycles", valid_hi, 32'd1);
    check_output("t1_count", got.size(), 32'd1);
    check_output("t1_data", got_at(0), 32'hA5);
    check_output("t1_frame_err", fe_cnt, 32'd0);
    check_output("t1_busy", {31'd0, busy}, 32'h0);

    $display("[TB] one-cycle glitch");
    busy_cnt = 0; rise0 = rise_cnt;
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    apply_stimulus_idle(10);
    check_output("t2_busy_short", {31'd0, (busy_cnt > 0 && busy_cnt <= HALF + 1)}, 32'd1);
    check_output("t2_no_valid", rise_cnt - rise0, 32'd0);

    $display("[TB] framing error, long break, then 0x55");
    fe_cnt = 0; got.delete();
    send_frame(8'h3C, 1'b0, -1);
    apply_stimulus_idle(20);
    rx = 1'b1;
    apply_stimulus_idle(8);
    send_frame(8'h55, 1'b1, -1);
    apply_stimulus_idle(8);
    check_output("t3_fe_pulses", fe_cnt, 32'd1);
    check_output("t3_count", got.size(), 32'd1);
    check_output("t3_data", got_at(0), 32'h55);

    $display("[TB] overrun with ready low");
    ready = 1'b0; got.delete();
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    apply_stimulus_idle(8);
    check_output("t4_valid", {31'd0, valid}, 32'd1);
    check_output("t4_data", {24'd0, data}, 32'h11);
    check_output("t4_overrun", {31'd0, overrun}, 32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check_output("t4_valid_cleared", {31'd0, valid}, 32'd0);
    check_output("t4_overrun_cleared", {31'd0, overrun}, 32'd0);
    check_output("t4_accepted", got_at(0), 32'h11);
    apply_stimulus_idle(4);

    $display("[TB] back-to-back frames");
    ready = 1'b1; got.delete(); fe_cnt = 0;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h80, 1'b1, -1);
    apply_stimulus_idle(8);
    check_output("t5_count", got.size(), 32'd3);
    check_output("t5_byte0", got_at(0), 32'h00);
    check_output("t5_byte1", got_at(1), 32'hFF);
    check_output("t5_byte2", got_at(2), 32'h80);
    check_output("t5_frame_err", fe_cnt, 32'd0);

    $display("[TB] reset mid-frame");
    got.delete();
    send_frame(8'h5A, 1'b1, 20);
    #2 rst = 1'b1;
    #1;
    check_output("t6_rst_data", {24'd0, data}, 32'h0);
    check_output("t6_rst_busy", {31'd0, busy}, 32'h0);
    check_output("t6_rst_valid", {31'd0, valid}, 32'h0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply_stimulus_idle(3);
    send_frame(8'hC3, 1'b1, -1);
    apply_stimulus_idle(8);
    check_output("t6_count", got.size(), 32'd1);
    check_output("t6_data", got_at(0), 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
